uart_tx_arbiter: RTL and testbench

//   Shares one uart_tx6 transmit FIFO among NUM_REQ byte-stream requesters
//   (e.g. PicoBlaze console, debug dump, status beacon).

---
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that lets NUM_REQ byte streams share one
// uart_tx6 transmit FIFO, with a per-grant burst cap and an idle watchdog on the owner.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   tx_full,
  output logic [7:0]             tx_data,
  output logic                   tx_write,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   dbg_state
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
  localparam logic [LW-1:0] LAST_INIT  = LW'(NUM_REQ - 1);

  // Handshake: a byte moves on a cycle where req_valid[i] and req_ready[i] are
  // both high; tx_write pulses on exactly those cycles and only for the owner.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [LW-1:0]        owner_q, owner_d;
  logic [LW-1:0]        last_grant_q, last_grant_d;
  logic [BW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]        idle_cnt_q, idle_cnt_d;

  logic                 any_valid;
  logic [LW-1:0]        pick_idx;
  logic [LW-1:0]        cand;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 fire;
  logic                 release_now;

  // Search from the farthest offset down so the nearest valid index after
  // last_grant is the one left standing.
  always_comb begin
    any_valid = 1'b0;
    pick_idx  = '0;
    cand      = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = LW'((int'(last_grant_q) + off) % NUM_REQ);
      if (req_valid[cand]) begin
        any_valid = 1'b1;
        pick_idx  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    req_ready    = '0;
    tx_write     = 1'b0;
    tx_data      = '0;
    owner_valid  = req_valid[owner_q];
    owner_last   = req_last[owner_q];
    fire         = 1'b0;
    release_now  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d           = XFER;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          byte_cnt_d        = '0;
          idle_cnt_d        = '0;
        end
      end
      XFER: begin
        // Reset gating keeps a byte from slipping out on the reset cycle itself.
        req_ready[owner_q] = !tx_full && !reset;
        fire               = owner_valid && !tx_full && !reset;
        tx_write           = fire;
        if (fire) begin
          tx_data     = req_data[{owner_q, 3'b000} +: 8];
          byte_cnt_d  = byte_cnt_q + 1'b1;
          idle_cnt_d  = '0;
          release_now = owner_last || (byte_cnt_q == BURST_LAST);
        end else if (!owner_valid) begin
          if (idle_cnt_q == IDLE_LAST) begin
            release_now = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        if (release_now) begin
          state_d      = IDLE;
          grant_d      = '0;
          last_grant_d = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= LAST_INIT;
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == XFER);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue requesters, a rule-level reference model
// of the arbiter, directed scenarios and a randomized soak.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int MAX_BURST    = 16;
  localparam int IDLE_TIMEOUT = 64;
  localparam int BUF          = 512;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_full;
  logic [7:0]           tx_data;
  logic                 tx_write;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 dbg_state;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MAX_BURST(MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_full(tx_full),
    .tx_data(tx_data),
    .tx_write(tx_write),
    .grant(grant),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_vec;
  int n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];

  // Requester byte sources
  logic [7:0] src_data [NUM_REQ][BUF];
  logic       src_last [NUM_REQ][BUF];
  int         head [NUM_REQ];
  int         tail [NUM_REQ];
  int         vpct [NUM_REQ];
  int         full_pct;

  // Reference model: current owner (-1 when none), previous owner, bytes sent
  // in this grant, consecutive idle cycles of the owner.
  int m_owner;
  int m_last;
  int m_bytes;
  int m_idle;

  logic [NUM_REQ-1:0] obs_grant;
  logic               obs_write;
  logic [7:0]         obs_data;

  logic [7:0] t2_exp [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic enqueue_msg(input int r, input int len, input logic [7:0] base, input bit with_last);
    if (head[r] == tail[r]) begin
      head[r] = 0;
      tail[r] = 0;
    end
    for (int k = 0; k < len; k++) begin
      if (tail[r] < BUF) begin
        src_data[r][tail[r]] = base + 8'(k);
        src_last[r][tail[r]] = with_last && (k == len - 1);
        tail[r]++;
      end
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      vpct[i] = 100;
    end
    full_pct = 0;
  endtask

  // One clock: drive at negedge, compare against the model, advance sources and model.
  task automatic step(input bit rst);
    logic [NUM_REQ-1:0] exp_grant;
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_write;
    logic [7:0]         exp_data;
    bit                 fire;
    bit                 fire_last;
    bit                 has;
    int                 nxt;
    @(negedge clk);
    reset = rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      has                = head[i] < tail[i];
      req_valid[i]       = has && ($urandom_range(0, 99) < vpct[i]);
      req_data[8*i +: 8] = has ? src_data[i][head[i]] : 8'($urandom);
      req_last[i]        = has ? src_last[i][head[i]] : 1'($urandom);
    end
    tx_full = ($urandom_range(0, 99) < full_pct);
    #1;
    obs_grant = grant;
    obs_write = tx_write;
    obs_data  = tx_data;

    exp_grant = '0;
    exp_ready = '0;
    exp_write = 1'b0;
    exp_data  = 8'h00;
    fire      = 1'b0;
    fire_last = 1'b0;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      if (!rst && !tx_full) exp_ready[m_owner] = 1'b1;
      fire = !rst && !tx_full && req_valid[m_owner];
      if (fire) begin
        exp_write = 1'b1;
        exp_data  = src_data[m_owner][head[m_owner]];
        fire_last = src_last[m_owner][head[m_owner]];
        exp_q.push_back(exp_data);
      end
    end

    if (!rst) begin
      check_eq("grant", grant, exp_grant);
      check_eq("busy", busy, m_owner >= 0);
      check_eq("dbg_state", dbg_state, m_owner >= 0);
      check_eq("req_ready", req_ready, exp_ready);
      check_eq("tx_write", tx_write, exp_write);
      check_eq("tx_data", tx_data, exp_data);
      check_eq("grant_onehot", $countones(grant) <= 1, 1);
      check_eq("write_while_full", tx_write && tx_full, 0);
    end

    // Scoreboard: every DUT write must match the oldest predicted byte.
    if (tx_write) begin
      tx_log.push_back(tx_data);
      check_eq("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("sb_byte", tx_data, exp_q.pop_front());
    end

    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && req_ready[i]) head[i]++;

    if (rst) begin
      m_owner = -1;
      m_last  = NUM_REQ - 1;
      m_bytes = 0;
      m_idle  = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        nxt = (m_last + k) % NUM_REQ;
        if (m_owner < 0 && req_valid[nxt]) begin
          m_owner = nxt;
          m_bytes = 0;
          m_idle  = 0;
        end
      end
    end else if (fire) begin
      m_bytes++;
      m_idle = 0;
      if (fire_last || m_bytes == MAX_BURST) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (!req_valid[m_owner]) begin
      m_idle++;
      if (m_idle == IDLE_TIMEOUT) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt;
    n_vec     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_full   = 1'b0;
    m_owner   = -1;
    m_last    = NUM_REQ - 1;
    m_bytes   = 0;
    m_idle    = 0;
    t2_exp    = '{8'hA0, 8'hA1, 8'hC0, 8'hC1, 8'hA2, 8'hA3, 8'hC2, 8'hC3};
    clear_sources();

    // Reset state
    step(1);
    step(1);
    step(0);
    check_eq("rst_grant", obs_grant, 4'b0000);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", req_ready, 4'b0000);
    check_eq("rst_write", obs_write, 0);
    check_eq("rst_data", obs_data, 8'h00);

    // 1: single 3-byte message from req0
    clear_sources();
    step(1);
    enqueue_msg(0, 3, 8'h41, 1'b1);
    step(0);
    check_eq("t1_arb_grant", obs_grant, 4'b0000);
    check_eq("t1_arb_write", obs_write, 0);
    step(0);
    check_eq("t1_grant", obs_grant, 4'b0001);
    check_eq("t1_byte0", {obs_write, obs_data}, 9'h141);
    step(0);
    check_eq("t1_byte1", {obs_write, obs_data}, 9'h142);
    step(0);
    check_eq("t1_byte2", {obs_write, obs_data}, 9'h143);
    step(0);
    check_eq("t1_release", obs_grant, 4'b0000);

    // 2: req0 and req2 round robin, no interleaving
    clear_sources();
    step(1);
    tx_log.delete();
    enqueue_msg(0, 2, 8'hA0, 1'b1);
    enqueue_msg(2, 2, 8'hC0, 1'b1);
    repeat (10) step(0);
    enqueue_msg(0, 2, 8'hA2, 1'b1);
    enqueue_msg(2, 2, 8'hC2, 1'b1);
    repeat (10) step(0);
    check_eq("t2_count", tx_log.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < tx_log.size()) check_eq($sformatf("t2_byte%0d", k), tx_log[k], t2_exp[k]);

    // 3: burst cap forces req1 to yield to req3, then resume
    clear_sources();
    step(1);
    tx_log.delete();
    enqueue_msg(1, 40, 8'h00, 1'b0);
    enqueue_msg(3, 3, 8'hE0, 1'b1);
    repeat (60) step(0);
    check_eq("t3_count", tx_log.size(), 43);
    for (int k = 0; k < 43; k++) begin
      if (k < tx_log.size()) begin
        if (k < MAX_BURST)          check_eq("t3_req1_a", tx_log[k], k);
        else if (k < MAX_BURST + 3) check_eq("t3_req3", tx_log[k], 8'hE0 + k - MAX_BURST);
        else                        check_eq("t3_req1_b", tx_log[k], k - 3);
      end
    end

    // 4: long FIFO backpressure holds the grant without release
    clear_sources();
    step(1);
    enqueue_msg(0, 1, 8'h5A, 1'b1);
    step(0);
    full_pct = 100;
    cnt = 0;
    repeat (200) begin
      step(0);
      if (obs_write) cnt++;
    end
    check_eq("t4_no_write", cnt, 0);
    check_eq("t4_held", obs_grant, 4'b0001);
    full_pct = 0;
    step(0);
    check_eq("t4_write", {obs_write, obs_data}, 9'h15A);

    // 5: owner goes quiet mid-message; watchdog releases it
    clear_sources();
    step(1);
    tx_log.delete();
    enqueue_msg(2, 2, 8'h70, 1'b0);
    for (int c = 0; c < 20 && tx_log.size() < 2; c++) step(0);
    check_eq("t5_sent", tx_log.size(), 2);
    enqueue_msg(3, 1, 8'h90, 1'b1);
    cnt = 0;
    while (obs_grant == 4'b0100 && cnt < 200) begin
      step(0);
      if (obs_grant == 4'b0100) cnt++;
    end
    check_eq("t5_idle_cycles", cnt, IDLE_TIMEOUT);
    check_eq("t5_gap", obs_grant, 4'b0000);
    step(0);
    check_eq("t5_next_owner", obs_grant, 4'b1000);

    // 6: reset during req2 burst, then req0 wins first
    clear_sources();
    step(1);
    tx_log.delete();
    enqueue_msg(2, 10, 8'h30, 1'b0);
    for (int c = 0; c < 20 && tx_log.size() < 3; c++) step(0);
    check_eq("t6_sent", tx_log.size(), 3);
    enqueue_msg(0, 1, 8'hB0, 1'b1);
    step(1);
    step(0);
    check_eq("t6_grant", obs_grant, 4'b0000);
    check_eq("t6_write", obs_write, 0);
    check_eq("t6_log", tx_log.size(), 3);
    step(0);
    check_eq("t6_req0_first", obs_grant, 4'b0001);

    // Randomized soak
    clear_sources();
    step(1);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 500 == 0) full_pct = (cyc / 500) % 3 == 0 ? 0 : ((cyc / 500) % 3 == 1 ? 20 : 50);
      if (cyc % 200 == 0)
        for (int i = 0; i < NUM_REQ; i++) vpct[i] = $urandom_range(60, 100);
      if ($urandom_range(0, 9) == 0)
        enqueue_msg($urandom_range(0, NUM_REQ - 1), $urandom_range(1, 24),
                    8'($urandom), $urandom_range(0, 99) < 85);
      step($urandom_range(0, 1499) == 0);
    end
    full_pct = 0;
    for (int i = 0; i < NUM_REQ; i++) vpct[i] = 100;
    repeat (300) step(0);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
